pwm_shadow_controller: RTL and testbench

Double-buffered configuration controller for one PWM device. Holds bus-written shadow values for the counter top and per-output compare registers, and commits them atomically into the active registers at the device's period boundary, so an output never sees a half-updated period. Sits between the peripheral register file and the PWM counter/compare datapath, one instance per device.

---
 rtl/pwm_shadow_controller_pkg.sv | 13 +
 rtl/pwm_shadow_controller_if.sv | 24 ++
 rtl/pwm_commit_timer.sv | 24 ++
 rtl/pwm_shadow_controller.sv | 128 ++++++++++++
 tb/tb_pwm_shadow_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_shadow_controller_pkg.sv
// Shared types and defaults for the PWM shadow/commit controller.
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int unsigned SELECT_TOP      = 0;
  localparam int unsigned DEFAULT_WIDTH   = 16;
  localparam int unsigned DEFAULT_OUTPUTS = 4;

endpackage

// File: rtl/pwm_shadow_controller_if.sv
// Shadow-register write bus between the register file (master) and the controller (slave).
interface pwm_shadow_controller_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned OUTPUTS = DEFAULT_OUTPUTS
);
  localparam int unsigned SEL_W = $clog2(OUTPUTS + 1);

  logic             shadowWriteEnable;
  logic [SEL_W-1:0] shadowWriteSelect;
  logic [WIDTH-1:0] shadowWriteData;
  logic             shadowWriteReject;

  modport master (
    output shadowWriteEnable, shadowWriteSelect, shadowWriteData,
    input  shadowWriteReject
  );

  modport slave (
    input  shadowWriteEnable, shadowWriteSelect, shadowWriteData,
    output shadowWriteReject
  );
endinterface

// File: rtl/pwm_commit_timer.sv
// Counts cycles spent waiting for a commit; flags the last permitted waiting cycle.
module pwm_commit_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_shadow_controller.sv
// Double-buffered top/compare registers committed atomically at the PWM period boundary.
// Optional forced-commit timeout is enabled by defining PWM_SHADOW_TIMEOUT_EN.
module pwm_shadow_controller
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH          = DEFAULT_WIDTH,
  parameter int unsigned OUTPUTS        = DEFAULT_OUTPUTS,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  pwm_shadow_controller_if.slave   wr,
  input  logic                     commitRequest,
  input  logic                     commitImmediate,
  input  logic                     counterEnable,
  input  logic                     counterWrap,
  output logic [WIDTH-1:0]         activeTop,
  output logic [OUTPUTS*WIDTH-1:0] activeCompare,
  output logic                     commitPending,
  output logic                     commitDone
`ifdef PWM_SHADOW_TIMEOUT_EN
  ,
  output logic                     commitTimeout
`endif
);
  localparam int unsigned SEL_W = $clog2(OUTPUTS + 1);

  state_t state, state_nx;

  logic [WIDTH-1:0]              shadow_top, top_nx;
  logic [OUTPUTS-1:0][WIDTH-1:0] shadow_cmp, cmp_nx, cmp_clamped, active_cmp;
  logic                          do_commit, reject_nx, req_accept, timer_expired;

`ifdef PWM_SHADOW_TIMEOUT_EN
  pwm_commit_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state == PENDING),
    .clear   (do_commit),
    .expired (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // Shadow next-values are computed first so a same-cycle write is part of the commit.
  always_comb begin
    top_nx     = shadow_top;
    cmp_nx     = shadow_cmp;
    state_nx   = state;
    do_commit  = 1'b0;
    reject_nx  = 1'b0;
    req_accept = 1'b0;

    if (wr.shadowWriteEnable) begin
      if (state == PENDING) begin
        reject_nx = 1'b1;
      end else if (wr.shadowWriteSelect == SEL_W'(SELECT_TOP)) begin
        top_nx = wr.shadowWriteData;
      end else begin
        for (int unsigned k = 0; k < OUTPUTS; k++) begin
          if (wr.shadowWriteSelect == SEL_W'(k + 1)) cmp_nx[k] = wr.shadowWriteData;
        end
      end
    end

    unique case (state)
      IDLE: begin
        req_accept = commitRequest;
        if (commitImmediate || (commitRequest && !counterEnable)) begin
          do_commit = 1'b1;
        end else if (commitRequest) begin
          state_nx = PENDING;
        end
      end
      PENDING: begin
        if (counterWrap || commitImmediate || !counterEnable || timer_expired) begin
          do_commit = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    for (int unsigned k = 0; k < OUTPUTS; k++) begin
      cmp_clamped[k] = (cmp_nx[k] > top_nx) ? top_nx : cmp_nx[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      shadow_top           <= '0;
      shadow_cmp           <= '0;
      activeTop            <= '0;
      active_cmp           <= '0;
      commitDone           <= 1'b0;
      wr.shadowWriteReject <= 1'b0;
    end else begin
      state                <= state_nx;
      shadow_top           <= top_nx;
      shadow_cmp           <= cmp_nx;
      commitDone           <= do_commit;
      wr.shadowWriteReject <= reject_nx;
      if (do_commit) begin
        activeTop  <= top_nx;
        active_cmp <= cmp_clamped;
      end
    end
  end

`ifdef PWM_SHADOW_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      commitTimeout <= 1'b0;
    end else if (timer_expired) begin
      commitTimeout <= 1'b1;
    end else if (req_accept) begin
      commitTimeout <= 1'b0;
    end
  end
`endif

  assign commitPending = (state == PENDING);
  assign activeCompare = active_cmp;
endmodule

// File: tb/tb_pwm_shadow_controller.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_pwm_shadow_controller;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst, cr, ci, ce, wrap;
  logic [W-1:0]   a_top;
  logic [N*W-1:0] a_cmp;
  logic           pend, done;
  logic           tmo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pwm_shadow_controller_if #(.WIDTH(W), .OUTPUTS(N)) bus ();

  pwm_shadow_controller #(
    .WIDTH(W), .OUTPUTS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr              (bus),
    .commitRequest   (cr),
    .commitImmediate (ci),
    .counterEnable   (ce),
    .counterWrap     (wrap),
    .activeTop       (a_top),
    .activeCompare   (a_cmp),
    .commitPending   (pend),
    .commitDone      (done)
`ifdef PWM_SHADOW_TIMEOUT_EN
    ,
    .commitTimeout   (tmo)
`endif
  );

`ifndef PWM_SHADOW_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  // Behavioural model: shadow/active values as plain arrays, commit decided from the rules.
  int m_sh_top, m_top, m_pend, m_done, m_rej, m_tmo, m_wait;
  int m_sh_cmp[N];
  int m_cmp[N];

  always @(posedge clk) begin
    bit commit;
    int s;
    if (rst) begin
      m_sh_top = 0; m_top = 0; m_pend = 0; m_done = 0; m_rej = 0; m_tmo = 0; m_wait = 0;
      for (int k = 0; k < N; k++) begin m_sh_cmp[k] = 0; m_cmp[k] = 0; end
    end else begin
      commit = 0;
      s = int'(bus.shadowWriteSelect);
      m_rej = (bus.shadowWriteEnable && m_pend) ? 1 : 0;
      if (bus.shadowWriteEnable && !m_pend) begin
        if (s == 0) m_sh_top = int'(bus.shadowWriteData);
        else if (s <= N) m_sh_cmp[s-1] = int'(bus.shadowWriteData);
      end
      if (!m_pend) begin
        if (cr) m_tmo = 0;
        if (ci || (cr && !ce)) commit = 1;
        else if (cr) m_pend = 1;
      end else begin
        m_wait++;
        if (wrap || ci || !ce) commit = 1;
`ifdef PWM_SHADOW_TIMEOUT_EN
        if (m_wait == TO && !commit) begin commit = 1; m_tmo = 1; end
`endif
      end
      if (commit) begin
        m_top = m_sh_top;
        for (int k = 0; k < N; k++) m_cmp[k] = (m_sh_cmp[k] < m_sh_top) ? m_sh_cmp[k] : m_sh_top;
        m_pend = 0;
        m_wait = 0;
      end
      m_done = commit ? 1 : 0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N*W-1:0] exp_cmp;
    if (chk_en) begin
      for (int k = 0; k < N; k++) exp_cmp[k*W +: W] = W'(m_cmp[k]);
      check("model_top", a_top, m_top);
      check("model_cmp", a_cmp, exp_cmp);
      check("model_pending", pend, m_pend);
      check("model_done", done, m_done);
      check("model_reject", bus.shadowWriteReject, m_rej);
      check("model_timeout", tmo, m_tmo);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_reg(input int sel, input int data);
    bus.shadowWriteEnable = 1'b1;
    bus.shadowWriteSelect = 3'(sel);
    bus.shadowWriteData   = W'(data);
    cyc();
    bus.shadowWriteEnable = 1'b0;
  endtask

  function automatic int cmp_ch(input logic [N*W-1:0] v, input int k);
    return int'(v[k*W +: W]);
  endfunction

  initial begin
    rst = 1'b1; cr = 0; ci = 0; ce = 0; wrap = 0;
    bus.shadowWriteEnable = 0; bus.shadowWriteSelect = '0; bus.shadowWriteData = '0;
    repeat (3) cyc();
    check("reset_top", a_top, 0);
    check("reset_cmp", a_cmp, 0);
    check("reset_pending", pend, 0);
    check("reset_done", done, 0);
    check("reset_reject", bus.shadowWriteReject, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Wrap commit
    ce = 1;
    wr_reg(0, 999);
    wr_reg(1, 500);
    cr = 1; cyc(); cr = 0;
    check("wrap_pending_entry", pend, 1);
    repeat (19) cyc();
    check("wrap_pending_hold", pend, 1);
    check("wrap_top_before", a_top, 0);
    wrap = 1; cyc(); wrap = 0;
    check("wrap_top_after", a_top, 999);
    check("wrap_cmp0_after", cmp_ch(a_cmp, 0), 500);
    check("wrap_done", done, 1);
    cyc();
    check("wrap_done_single", done, 0);

    // Write refused in PENDING
    cr = 1; cyc(); cr = 0;
    wr_reg(2, 300);
    check("pend_reject", bus.shadowWriteReject, 1);
    cyc();
    check("pend_reject_single", bus.shadowWriteReject, 0);
    wrap = 1; cyc(); wrap = 0;
    check("pend_cmp1_unchanged", cmp_ch(a_cmp, 1), 0);

    // Clamp
    wr_reg(0, 100);
    wr_reg(3, 250);
    ci = 1; cyc(); ci = 0;
    check("clamp_cmp2", cmp_ch(a_cmp, 2), 100);
    check("clamp_cmp0", cmp_ch(a_cmp, 0), 100);

    // Disabled counter: commit without PENDING
    ce = 0;
    wr_reg(0, 700);
    cr = 1; cyc(); cr = 0;
    check("dis_done", done, 1);
    check("dis_pending", pend, 0);
    check("dis_top", a_top, 700);
    check("dis_cmp2", cmp_ch(a_cmp, 2), 250);

    // Counter dropped while PENDING
    ce = 1;
    wr_reg(0, 40);
    cr = 1; cyc(); cr = 0;
    check("drop_pending", pend, 1);
    ce = 0; cyc(); ce = 1;
    check("drop_done", done, 1);
    check("drop_cmp0", cmp_ch(a_cmp, 0), 40);

    // Same-cycle write and immediate commit; out-of-range select ignored
    bus.shadowWriteEnable = 1; bus.shadowWriteSelect = 3'd0; bus.shadowWriteData = 16'd1234;
    ci = 1; cyc(); ci = 0; bus.shadowWriteEnable = 0;
    check("same_cycle_top", a_top, 1234);
    wr_reg(5, 77);
    check("oor_no_reject", bus.shadowWriteReject, 0);

    // Reset mid-PENDING
    wr_reg(0, 555);
    cr = 1; cyc(); cr = 0;
    rst = 1; cyc();
    check("rst_pend_done", done, 0);
    check("rst_pend_top", a_top, 0);
    check("rst_pend_pending", pend, 0);
    rst = 0; cyc();
    check("rst_pend_no_done", done, 0);

`ifdef PWM_SHADOW_TIMEOUT_EN
    ce = 1;
    cr = 1; cyc(); cr = 0;
    repeat (TO - 1) cyc();
    check("to_still_pending", pend, 1);
    cyc();
    check("to_done", done, 1);
    check("to_flag", tmo, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.shadowWriteEnable = ($urandom_range(0, 9) < 3);
      bus.shadowWriteSelect = 3'($urandom_range(0, 7));
      bus.shadowWriteData   = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 300)) : W'($urandom);
      cr   = ($urandom_range(0, 9) == 0);
      ci   = ($urandom_range(0, 29) == 0);
      ce   = ($urandom_range(0, 19) != 0);
      wrap = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 0; cr = 0; ci = 0; wrap = 0; bus.shadowWriteEnable = 0;
    cyc();
    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
